bf_sram_ctrl: RTL and testbench

- Sequencer for the 1-bit x 2^17 true dual-port Bloom-filter bit SRAM.
- Accepts INSERT and QUERY requests, each carrying two base hashes (h1, h2), and expands them into NUM_HASH bit indices using Kirsch-Mitzenmacher double hashing.
- Drives both SRAM ports to set or test two bits per cycle.
- Also performs a full-array clear sweep.
- Sits between the Bloom-filter request logic and the sram macro instance.

---
 rtl/bf_sram_ctrl.sv | 154 +++++++++++++++
 tb/tb_bf_sram_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_sram_ctrl.sv
// rtl/bf_sram_ctrl.sv - Bloom-filter bit-SRAM sequencer (insert/query/clear); BF_AUTO_CLEAR_EN clears after reset
module bf_sram_ctrl #(
    parameter int ADDR_W   = 17,
    parameter int NUM_HASH = 4,
    parameter int RD_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_h1,
    input  logic [ADDR_W-1:0] req_h2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_address_a,
    output logic              sram_data_a,
    output logic              sram_wren_a,
    input  logic              sram_q_a,
    output logic [ADDR_W-1:0] sram_address_b,
    output logic              sram_data_b,
    output logic              sram_wren_b,
    input  logic              sram_q_b
);
    localparam int                ISSUE_CYC = (NUM_HASH + 1) / 2;
    localparam logic [3:0]        K_LAST    = 4'(ISSUE_CYC - 1);
    localparam logic              ODD_HASH  = 1'(NUM_HASH % 2);
    localparam logic [ADDR_W-1:0] CLR_LAST  = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [RD_LAT-1:0] PIPE_LAST = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, INSERT, Q_ISSUE, Q_DRAIN, RSP} state_t;

`ifdef BF_AUTO_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state, state_nx;
    logic [ADDR_W-1:0] acc_a, acc_b, step;
    logic [3:0]        k;
    logic [RD_LAT-1:0] pipe, pipe_b;
    logic              hit, done_q;
    logic              last_issue, b_used, take, start_clear;
    logic              rdy_c, busy_c, wren_a_c, wren_b_c, data_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        rdy_c       = 1'b0;
        busy_c      = 1'b1;
        wren_a_c    = 1'b0;
        wren_b_c    = 1'b0;
        data_c      = 1'b0;
        take        = 1'b0;
        start_clear = 1'b0;
        last_issue  = (k == K_LAST);
        b_used      = !(ODD_HASH && last_issue);
        unique case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (clear_req) begin
                    start_clear = 1'b1;
                    state_nx    = CLEAR;
                end else begin
                    rdy_c = 1'b1;
                    if (req_valid) begin
                        take     = 1'b1;
                        state_nx = req_op ? Q_ISSUE : INSERT;
                    end
                end
            end
            CLEAR: begin
                wren_a_c = 1'b1;
                wren_b_c = 1'b1;
                if (acc_a == CLR_LAST) state_nx = IDLE;
            end
            INSERT: begin
                // A dual write to one address is undefined on the macro; port A alone covers it.
                wren_a_c = 1'b1;
                wren_b_c = b_used && (acc_a != acc_b);
                data_c   = 1'b1;
                if (last_issue) state_nx = IDLE;
            end
            Q_ISSUE: begin
                if (last_issue) state_nx = Q_DRAIN;
            end
            Q_DRAIN: begin
                if (pipe == PIPE_LAST) state_nx = RSP;
            end
            RSP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_a  <= '0;
            acc_b  <= '0;
            step   <= '0;
            k      <= '0;
            pipe   <= '0;
            pipe_b <= '0;
            hit    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // pipe tracks each read in flight; its top bit marks the cycle q is valid
            pipe   <= (pipe << 1) | RD_LAT'(state == Q_ISSUE);
            pipe_b <= (pipe_b << 1) | RD_LAT'((state == Q_ISSUE) && b_used);
            done_q <= (state == CLEAR) && (state_nx == IDLE);
            if (pipe[RD_LAT-1])
                hit <= hit & sram_q_a & (sram_q_b | ~pipe_b[RD_LAT-1]);
            if (take) begin
                acc_a <= req_h1;
                acc_b <= req_h1 + req_h2;
                step  <= req_h2 << 1;
                k     <= '0;
                hit   <= 1'b1;
            end else if (start_clear) begin
                acc_a <= '0;
            end else if (state == CLEAR) begin
                acc_a <= acc_a + ADDR_W'(2);
            end else if ((state == INSERT) || (state == Q_ISSUE)) begin
                acc_a <= acc_a + step;
                acc_b <= acc_b + step;
                k     <= k + 4'd1;
            end
        end
    end

    // Combinational outputs are held low for as long as reset is asserted.
    assign req_ready      = rdy_c & reset_n;
    assign busy           = busy_c & reset_n;
    assign sram_wren_a    = wren_a_c & reset_n;
    assign sram_wren_b    = wren_b_c & reset_n;
    assign sram_data_a    = data_c;
    assign sram_data_b    = data_c;
    assign sram_address_a = acc_a;
    assign sram_address_b = ((state == CLEAR) && reset_n) ? {acc_a[ADDR_W-1:1], 1'b1} : acc_b;
    assign rsp_valid      = (state == RSP);
    assign rsp_hit        = (state == RSP) && hit;
    assign clear_done     = done_q;

endmodule

// File: tb/tb_bf_sram_ctrl.sv
// tb/tb_bf_sram_ctrl.sv - self-checking bench for bf_sram_ctrl with SRAM model and set-based reference
module tb_bf_sram_ctrl;
    localparam int AW      = 14;
    localparam int NH      = 4;
    localparam int RDL     = 2;
    localparam int C       = (NH + 1) / 2;
    localparam int M       = (1 << AW) - 1;
    localparam int CLR_CYC = 1 << (AW - 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0, req_op = 1'b0, rsp_ready = 1'b0, clear_req = 1'b0;
    logic [AW-1:0] req_h1 = '0, req_h2 = '0;
    logic          req_ready, rsp_valid, rsp_hit, clear_done, busy;
    logic [AW-1:0] sram_address_a, sram_address_b;
    logic          sram_data_a, sram_wren_a, sram_q_a, sram_data_b, sram_wren_b, sram_q_b;

    int total = 0;
    int bad   = 0;

    bf_sram_ctrl #(.ADDR_W(AW), .NUM_HASH(NH), .RD_LAT(RDL)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_h1(req_h1), .req_h2(req_h2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
        .sram_address_a(sram_address_a), .sram_data_a(sram_data_a),
        .sram_wren_a(sram_wren_a), .sram_q_a(sram_q_a),
        .sram_address_b(sram_address_b), .sram_data_b(sram_data_b),
        .sram_wren_b(sram_wren_b), .sram_q_b(sram_q_b)
    );

    always #5 clock = ~clock;

    // SRAM model: synchronous write, RDL-cycle registered read
    logic       mem [0:M];
    logic [1:0] pa, pb;
    logic       scramble = 1'b1;
    always @(posedge clock) begin
        if (scramble) begin
            for (int i = 0; i <= M; i++) mem[i] <= 1'($urandom);
        end else begin
            if (sram_wren_a) mem[sram_address_a] <= sram_data_a;
            if (sram_wren_b) mem[sram_address_b] <= sram_data_b;
        end
        pa <= {pa[0], mem[sram_address_a]};
        pb <= {pb[0], mem[sram_address_b]};
    end
    assign sram_q_a = pa[1];
    assign sram_q_b = pb[1];

    logic          log_en = 1'b0;
    logic [AW:0]   wq[$];
    always @(negedge clock) begin
        if (log_en) begin
            if (sram_wren_a) wq.push_back({sram_data_a, sram_address_a});
            if (sram_wren_b) wq.push_back({sram_data_b, sram_address_b});
        end
    end

    logic ref_bits [0:M];

    function automatic int idx(input logic [AW-1:0] h1, input logic [AW-1:0] h2, input int j);
        return (int'(h1) + j * int'(h2)) & M;
    endfunction

    function automatic logic ref_query(input logic [AW-1:0] h1, input logic [AW-1:0] h2);
        logic r = 1'b1;
        for (int j = 0; j < NH; j++) r = r & ref_bits[idx(h1, h2, j)];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_req(input logic op, input logic [AW-1:0] h1, input logic [AW-1:0] h2,
                          input int hold, output logic hit);
        int n, viol, mism;
        logic [AW:0] expw[$];
        wq.delete();
        req_op = op; req_h1 = h1; req_h2 = h2; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        check("accept_timeout", 32'(n < 200), 1);
        log_en = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        n = 1;
        hit = 1'b0;
        if (op == 1'b0) begin
            while (!req_ready && n < 200) begin @(negedge clock); n++; end
            log_en = 1'b0;
            check("ins_latency", n, C + 1);
            for (int k = 0; k < C; k++) begin
                expw.push_back({1'b1, AW'(idx(h1, h2, 2 * k))});
                if (2 * k + 1 < NH && idx(h1, h2, 2 * k + 1) != idx(h1, h2, 2 * k))
                    expw.push_back({1'b1, AW'(idx(h1, h2, 2 * k + 1))});
            end
            check("ins_wr_count", wq.size(), expw.size());
            mism = 0;
            for (int i = 0; i < wq.size() && i < expw.size(); i++)
                if (wq[i] !== expw[i]) mism++;
            check("ins_wr_addr", mism, 0);
            for (int j = 0; j < NH; j++) ref_bits[idx(h1, h2, j)] = 1'b1;
        end else begin
            while (!rsp_valid && n < 200) begin @(negedge clock); n++; end
            log_en = 1'b0;
            check("qry_latency", n, C + RDL + 1);
            check("qry_no_write", wq.size(), 0);
            hit = rsp_hit;
            viol = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                if (!rsp_valid || rsp_hit !== hit || req_ready) viol++;
            end
            if (hold > 0) check("bp_stable", viol, 0);
            rsp_ready = 1'b1;
            @(negedge clock);
            rsp_ready = 1'b0;
            check("rsp_drop", rsp_valid, 0);
        end
    endtask

    task automatic wait_idle(input int bound, output int n, output int pulses);
        n = 0; pulses = 0;
        while (busy && n < bound) begin
            if (clear_done) pulses++;
            n++;
            @(negedge clock);
        end
        for (int i = 0; i < 4; i++) begin
            if (clear_done) pulses++;
            @(negedge clock);
        end
    endtask

    task automatic check_zero(input string name);
        int nz = 0;
        for (int i = 0; i <= M; i++) if (mem[i] !== 1'b0) nz++;
        check(name, nz, 0);
        for (int i = 0; i <= M; i++) ref_bits[i] = 1'b0;
    endtask

    task automatic run_clear();
        int n, pulses;
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        wait_idle(CLR_CYC + 100, n, pulses);
        check("clr_busy_cycles", n, CLR_CYC);
        check("clr_done_pulses", pulses, 1);
        check_zero("clr_all_zero");
    endtask

    typedef struct {
        logic          op;
        logic [AW-1:0] h1;
        logic [AW-1:0] h2;
        logic          exp_hit;
    } vec_t;
    vec_t vecs[12];

    initial begin
        logic          hit, exp;
        logic [AW-1:0] h1, h2;
        logic [2*AW-1:0] keys[$];
        int            n, pulses, viol;

        vecs[0]  = '{1'b0, AW'(16'h10), AW'(3), 1'b0};
        vecs[1]  = '{1'b1, AW'(16'h10), AW'(3), 1'b1};
        vecs[2]  = '{1'b1, AW'(16'h11), AW'(3), 1'b0};
        vecs[3]  = '{1'b0, AW'(M), AW'(0), 1'b0};
        vecs[4]  = '{1'b0, AW'(M - 1), AW'(1), 1'b0};
        vecs[5]  = '{1'b1, AW'(M), AW'(0), 1'b1};
        vecs[6]  = '{1'b1, AW'(0), AW'(1), 1'b0};
        vecs[7]  = '{1'b1, AW'(M - 1), AW'(1), 1'b1};
        vecs[8]  = '{1'b1, AW'(16'h10), AW'(0), 1'b1};
        vecs[9]  = '{1'b1, AW'(16'h19), AW'(M - 2), 1'b1};
        vecs[10] = '{1'b1, AW'(M), AW'(1), 1'b0};
        vecs[11] = '{1'b1, AW'(16'h13), AW'(3), 1'b0};

        repeat (3) @(negedge clock);
        scramble = 1'b0;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_wren_a", sram_wren_a, 0);
        check("rst_wren_b", sram_wren_b, 0);
        check("rst_addr_a", 32'(sram_address_a), 0);
        check("rst_addr_b", 32'(sram_address_b), 0);
        check("rst_busy", busy, 0);
        check("rst_clear_done", clear_done, 0);
        reset_n = 1'b1;
        #1;
`ifdef BF_AUTO_CLEAR_EN
        check("auto_busy", busy, 1);
        check("auto_ready", req_ready, 0);
        @(negedge clock);
        wait_idle(CLR_CYC + 100, n, pulses);
        check("auto_done_pulses", pulses, 1);
`else
        check("idle_ready", req_ready, 1);
        @(negedge clock);
`endif

        run_clear();

        foreach (vecs[i]) begin
            do_req(vecs[i].op, vecs[i].h1, vecs[i].h2, 0, hit);
            if (vecs[i].op) check($sformatf("vec%0d_hit", i), hit, vecs[i].exp_hit);
        end

        do_req(1'b1, AW'(16'h10), AW'(3), 10, hit);
        check("bp_hit", hit, 1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                h1 = AW'($urandom);
                h2 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
                keys.push_back({h1, h2});
                do_req(1'b0, h1, h2, 0, hit);
            end else begin
                if (keys.size() > 0 && $urandom_range(0, 1) == 1)
                    {h1, h2} = keys[$urandom_range(0, keys.size() - 1)];
                else begin
                    h1 = AW'($urandom);
                    h2 = AW'($urandom_range(0, 7));
                end
                exp = ref_query(h1, h2);
                do_req(1'b1, h1, h2, $urandom_range(0, 3), hit);
                check("rnd_hit", hit, exp);
            end
        end

        clear_req = 1'b1; req_valid = 1'b1; req_op = 1'b0;
        req_h1 = AW'(16'h20); req_h2 = AW'(5);
        #1;
        check("clr_prio_ready", req_ready, 0);
        @(negedge clock);
        clear_req = 1'b0;
        check("clr_prio_taken", busy, 1);
        n = 0; viol = 0;
        while (busy && n < CLR_CYC + 100) begin
            if (req_ready) viol++;
            n++;
            @(negedge clock);
        end
        check("clr_prio_blocked", viol, 0);
        check("clr_prio_cycles", n, CLR_CYC);
        check("clr_prio_ready_after", req_ready, 1);
        check_zero("clr_prio_zero");
        do_req(1'b0, AW'(16'h20), AW'(5), 0, hit);
        do_req(1'b1, AW'(16'h20), AW'(5), 0, hit);
        check("clr_prio_req_hit", hit, 1);

        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (100) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wren_a", sram_wren_a, 0);
        check("mid_rst_wren_b", sram_wren_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr_a", 32'(sram_address_a), 0);
        check("mid_rst_addr_b", 32'(sram_address_b), 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
`ifdef BF_AUTO_CLEAR_EN
        check("mid_rel_busy", busy, 1);
        check("mid_rel_addr_a", 32'(sram_address_a), 0);
        check("mid_rel_wren_a", sram_wren_a, 1);
        @(negedge clock);
        wait_idle(CLR_CYC + 100, n, pulses);
        check("mid_rel_clear_cycles", n, CLR_CYC - 1);
`else
        check("mid_rel_busy", busy, 0);
        check("mid_rel_ready", req_ready, 1);
        @(negedge clock);
`endif

        run_clear();
        do_req(1'b1, AW'(16'h10), AW'(3), 0, hit);
        check("post_clear_miss", hit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
